// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: periodic start pulse, 40-bit frame capture, checksum check,
// and a hysteretic over-temperature flag for the downstream controller.
module dht11_reader #(
  parameter int unsigned START_LOW_CYC  = 1_000_000,
  parameter int unsigned BIT_THRESH_CYC = 2_500,
  parameter int unsigned TIMEOUT_CYC    = 10_000,
  parameter int unsigned PERIOD_CYC     = 100_000_000,
  parameter int unsigned TEMP_ON        = 30,
  parameter int unsigned TEMP_OFF       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       data_valid,
  output logic       crc_err,
  output logic       timeout_err,
  output logic       too_hot,
  output logic       busy
);

  localparam int unsigned TimerMax0 = (START_LOW_CYC > TIMEOUT_CYC) ? START_LOW_CYC : TIMEOUT_CYC;
  localparam int unsigned TimerMax  = (TimerMax0 > BIT_THRESH_CYC) ? TimerMax0 : BIT_THRESH_CYC;
  localparam int unsigned TimerW    = $clog2(TimerMax + 1);
  localparam int unsigned PeriodW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStartLow = 3'd1;
  localparam logic [2:0] StRelease  = 3'd2;
  localparam logic [2:0] StRespLow  = 3'd3;
  localparam logic [2:0] StRespHigh = 3'd4;
  localparam logic [2:0] StBitLow   = 3'd5;
  localparam logic [2:0] StBitHigh  = 3'd6;
  localparam logic [2:0] StCheck    = 3'd7;

  logic               sync1_q, sync2_q, prev_q;
  logic               rise, fall;
  logic [2:0]         state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [39:0]        shift_q, shift_d;
  logic [7:0]         hum_q, hum_d, temp_q, temp_d;
  logic [7:0]         sum;
  logic               valid_q, valid_d;
  logic               crc_q, crc_d;
  logic               tmo_q, tmo_d;
  logic               hot_q, hot_d;
  logic               oe_q, busy_q;
  logic               period_wrap, timeout_hit, in_wait, bit_val;

  assign rise        = sync2_q & ~prev_q;
  assign fall        = ~sync2_q & prev_q;
  assign period_wrap = (period_q == PeriodW'(PERIOD_CYC - 1));
  assign timeout_hit = (timer_q == TimerW'(TIMEOUT_CYC - 1));
  assign in_wait     = (state_q >= StRelease) && (state_q <= StBitHigh);
  // Timer holds (high-phase count - 1) on the falling-edge cycle, so >= is "count > threshold".
  assign bit_val     = (timer_q >= TimerW'(BIT_THRESH_CYC));
  assign sum         = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hum_d     = hum_q;
    temp_d    = temp_q;
    valid_d   = 1'b0;
    crc_d     = crc_q;
    tmo_d     = tmo_q;
    hot_d     = hot_q;
    period_d  = period_wrap ? '0 : period_q + PeriodW'(1);

    case (state_q)
      StIdle: begin
        if (period_wrap) begin
          state_d   = StStartLow;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StStartLow: if (timer_q == TimerW'(START_LOW_CYC - 1)) state_d = StRelease;
      StRelease:  if (fall) state_d = StRespLow;
      StRespLow:  if (rise) state_d = StRespHigh;
      StRespHigh: if (fall) state_d = StBitLow;
      StBitLow:   if (rise) state_d = StBitHigh;
      StBitHigh: begin
        if (fall) begin
          shift_d   = {shift_q[38:0], bit_val};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
        end
      end
      StCheck: begin
        state_d = StIdle;
        tmo_d   = 1'b0;
        if (sum == shift_q[7:0]) begin
          hum_d   = shift_q[39:32];
          temp_d  = shift_q[23:16];
          valid_d = 1'b1;
          crc_d   = 1'b0;
          if (shift_q[23:16] >= 8'(TEMP_ON)) begin
            hot_d = 1'b1;
          end else if (shift_q[23:16] <= 8'(TEMP_OFF)) begin
            hot_d = 1'b0;
          end
        end else begin
          crc_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Wait states only leave on an edge, so "still here" means no edge arrived this cycle.
    if (in_wait && (state_d == state_q) && timeout_hit) begin
      state_d = StIdle;
      tmo_d   = 1'b1;
      crc_d   = 1'b0;
    end

    timer_d = (state_d != state_q || state_q == StIdle) ? '0 : timer_q + TimerW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= StIdle;
      timer_q   <= '0;
      period_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hum_q     <= '0;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      crc_q     <= 1'b0;
      tmo_q     <= 1'b0;
      hot_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= dht_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hum_q     <= hum_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      crc_q     <= crc_d;
      tmo_q     <= tmo_d;
      hot_q     <= hot_d;
      oe_q      <= (state_d == StStartLow);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign dht_oe      = oe_q;
  assign humidity    = hum_q;
  assign temperature = temp_q;
  assign data_valid  = valid_q;
  assign crc_err     = crc_q;
  assign timeout_err = tmo_q;
  assign too_hot     = hot_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a cycle-level DHT11 sensor model driving table-driven frames,
// plus hand-written timeout and mid-frame reset sequences.
module tb_dht11_reader;

  localparam int unsigned StartLow = 100;
  localparam int unsigned Timeout  = 500;
  localparam int unsigned Thresh   = 50;
  localparam int unsigned Period   = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_low = 1'b0;
  logic       dht_in;
  logic       dht_oe;
  logic [7:0] humidity, temperature;
  logic       data_valid, crc_err, timeout_err, too_hot, busy;

  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         valid_hum = 0;
  int         valid_temp = 0;

  // Open-drain line with pull-up: low if either host or sensor pulls it.
  assign dht_in = (dht_oe || sensor_low) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  dht11_reader #(
    .START_LOW_CYC (StartLow),
    .BIT_THRESH_CYC(Thresh),
    .TIMEOUT_CYC   (Timeout),
    .PERIOD_CYC    (Period),
    .TEMP_ON       (30),
    .TEMP_OFF      (28)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .humidity   (humidity),
    .temperature(temperature),
    .data_valid (data_valid),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .too_hot    (too_hot),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valid_cnt  = valid_cnt + 1;
      valid_hum  = int'(humidity);
      valid_temp = int'(temperature);
    end
  end

  typedef struct {
    logic [39:0] frame;
    int          slow_bit;
    int          hum;
    int          temp;
    int          crc;
    int          valid;
    int          hot;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_oe_rise(output int n);
    n = 0;
    while (dht_oe !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    if (dht_oe !== 1'b1) check("oe_rise_bound", 0, 1);
  endtask

  task automatic wait_oe_fall(output int n);
    n = 0;
    while (dht_oe === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("oe_len", n, StartLow);
  endtask

  task automatic send_bit(input int high);
    sensor_low = 1'b1;
    repeat (50) @(negedge clk);
    sensor_low = 1'b0;
    repeat (high) @(negedge clk);
  endtask

  task automatic send_response();
    repeat (20) @(negedge clk);
    sensor_low = 1'b1;
    repeat (80) @(negedge clk);
    sensor_low = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  // Entered on the first sample with dht_oe high; returns once the DHT11 is idle again.
  task automatic run_frame(input logic [39:0] f, input int slow_bit);
    int n;
    logic b;
    wait_oe_fall(n);
    send_response();
    for (int k = 0; k < 40; k++) begin
      b = f[39-k];
      send_bit(b ? 70 : ((k == slow_bit) ? 50 : 27));
    end
    sensor_low = 1'b1;
    repeat (50) @(negedge clk);
    sensor_low = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_end", int'(busy), 0);
  endtask

  initial begin
    int n;
    int m;
    logic [39:0] f6;

    vecs[0] = '{40'h37_00_1A_00_51, -1, 55, 26, 0, 1, 0};
    vecs[1] = '{40'h37_00_1A_00_52, -1, 55, 26, 1, 0, 0};
    vecs[2] = '{40'h37_00_1A_00_51, -1, 55, 26, 0, 1, 0};
    vecs[3] = '{40'h37_00_1E_00_55, -1, 55, 30, 0, 1, 1};
    vecs[4] = '{40'h37_00_1D_00_54,  8, 55, 29, 0, 1, 1};
    vecs[5] = '{40'h37_00_1C_00_53, -1, 55, 28, 0, 1, 0};
    vecs[6] = '{40'h37_00_1D_00_54, -1, 55, 29, 0, 1, 0};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("rst_oe", int'(dht_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_hum", int'(humidity), 0);
    check("rst_temp", int'(temperature), 0);
    check("rst_flags", int'({data_valid, crc_err, timeout_err, too_hot}), 0);

    for (int i = 0; i < 7; i++) begin
      wait_oe_rise(n);
      if (i == 0) check("first_start_cycle", n, Period);
      check("busy_with_oe", int'(busy), 1);
      valid_cnt = 0;
      run_frame(vecs[i].frame, vecs[i].slow_bit);
      check($sformatf("v%0d_hum", i), int'(humidity), vecs[i].hum);
      check($sformatf("v%0d_temp", i), int'(temperature), vecs[i].temp);
      check($sformatf("v%0d_crc", i), int'(crc_err), vecs[i].crc);
      check($sformatf("v%0d_tmo", i), int'(timeout_err), 0);
      check($sformatf("v%0d_hot", i), int'(too_hot), vecs[i].hot);
      check($sformatf("v%0d_valid_cnt", i), valid_cnt, vecs[i].valid);
      if (vecs[i].valid != 0) begin
        check($sformatf("v%0d_valid_hum", i), valid_hum, vecs[i].hum);
        check($sformatf("v%0d_valid_temp", i), valid_temp, vecs[i].temp);
      end
    end

    // Sensor silent: timeout 500 cycles after release, then retry on the next wrap.
    wait_oe_rise(n);
    valid_cnt = 0;
    wait_oe_fall(n);
    m = 0;
    while (timeout_err !== 1'b1 && m < 2000) begin
      @(negedge clk);
      m++;
    end
    check("timeout_latency", m, Timeout);
    check("timeout_busy", int'(busy), 0);
    check("timeout_crc", int'(crc_err), 0);
    check("timeout_hum_hold", int'(humidity), 55);
    check("timeout_temp_hold", int'(temperature), 29);
    check("timeout_no_valid", valid_cnt, 0);
    wait_oe_rise(n);
    check("retry_gap", n, Period - StartLow - Timeout);
    run_frame(40'h37_00_1E_00_55, -1);
    check("retry_tmo_clear", int'(timeout_err), 0);
    check("retry_temp", int'(temperature), 30);
    check("retry_hot", int'(too_hot), 1);
    check("retry_valid_cnt", valid_cnt, 1);

    // Reset during the high phase of bit 20.
    f6 = 40'h37_00_1A_00_51;
    wait_oe_rise(n);
    wait_oe_fall(n);
    send_response();
    for (int k = 0; k < 20; k++) send_bit(f6[39-k] ? 70 : 27);
    sensor_low = 1'b1;
    repeat (50) @(negedge clk);
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_frame_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_oe", int'(dht_oe), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_hum", int'(humidity), 0);
    check("mrst_temp", int'(temperature), 0);
    check("mrst_hot", int'(too_hot), 0);
    check("mrst_flags", int'({data_valid, crc_err, timeout_err}), 0);
    wait_oe_rise(n);
    check("mrst_restart_cycle", n, Period);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
